// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MDFunc codes, FSM states
// and the R-type funct codes that the ALU controller decodes into MDFunc.
package mul_div_unit_pkg;

  localparam logic [2:0] MDFUNC_MULT  = 3'd0;
  localparam logic [2:0] MDFUNC_MULTU = 3'd1;
  localparam logic [2:0] MDFUNC_DIV   = 3'd2;
  localparam logic [2:0] MDFUNC_DIVU  = 3'd3;
  localparam logic [2:0] MDFUNC_MTHI  = 3'd4;
  localparam logic [2:0] MDFUNC_MTLO  = 3'd5;
  localparam logic [2:0] MDFUNC_NOP   = 3'd7;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  function automatic logic mdfunc_is_mul(input logic [2:0] f);
    return (f == MDFUNC_MULT) || (f == MDFUNC_MULTU);
  endfunction

  function automatic logic mdfunc_is_div(input logic [2:0] f);
    return (f == MDFUNC_DIV) || (f == MDFUNC_DIVU);
  endfunction

  // Decode used by the ALU controller; MFHI/MFLO never start the unit.
  function automatic logic [2:0] funct_to_mdfunc(input logic [5:0] funct);
    case (funct)
      FUNCT_MULT:  return MDFUNC_MULT;
      FUNCT_MULTU: return MDFUNC_MULTU;
      FUNCT_DIV:   return MDFUNC_DIV;
      FUNCT_DIVU:  return MDFUNC_DIVU;
      FUNCT_MTHI:  return MDFUNC_MTHI;
      FUNCT_MTLO:  return MDFUNC_MTLO;
      FUNCT_MFHI,
      FUNCT_MFLO:  return MDFUNC_NOP;
      default:     return MDFUNC_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: Start is a single-cycle issue strobe. The unit takes it only
// while Busy is low (Busy acts as an inverted ready); a Start seen while
// Busy is high is dropped, so the issuer must stall on Busy. Done pulses
// for one cycle in the same cycle HI/LO first show a MULT/DIV result.
// Cancel aborts whatever is in flight and also suppresses a same-cycle Start.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       MDFunc;
  logic             Sign;
  logic             Cancel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;

  modport master (output Start, MDFunc, Sign, Cancel, A, B,
                  input  HI, LO, Busy, Done);
  modport slave  (input  Start, MDFunc, Sign, Cancel, A, B,
                  output HI, LO, Busy, Done);
endinterface

// File: rtl/md_iter_core.sv
// One-bit-per-cycle magnitude engine: shift-add multiply or restoring divide.
// Result appears as {hi, lo}: product, or remainder/quotient for divide.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,    // 0 multiply, 1 divide
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,    // multiplier / dividend magnitude
  input  logic [WIDTH-1:0] b_in,    // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  // acc is one bit wider so the partial remainder never loses its top bit
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_add;
  logic [WIDTH:0]   mul_acc_n;
  logic [WIDTH-1:0] mul_q_n;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   div_rest;
  logic             div_ok;
  logic [WIDTH:0]   div_acc_n;
  logic [WIDTH-1:0] div_q_n;

  // next-step values for both algorithms
  always_comb begin
    mul_add   = q[0] ? (acc + {1'b0, b_r}) : acc;
    mul_acc_n = {1'b0, mul_add[WIDTH:1]};
    mul_q_n   = {mul_add[0], q[WIDTH-1:1]};
    div_diff  = {acc, q[WIDTH-1]} - {2'b00, b_r};
    div_rest  = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_ok    = ~div_diff[WIDTH+1];
    div_acc_n = div_ok ? div_diff[WIDTH:0] : div_rest;
    div_q_n   = {q[WIDTH-2:0], div_ok};
  end

  // operand load and one iteration per step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      q   <= '0;
      b_r <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      q   <= a_in;
      b_r <= b_in;
      cnt <= '0;
    end else if (step) begin
      if (mode) begin
        acc <= div_acc_n;
        q   <= div_q_n;
      end else begin
        acc <= mul_acc_n;
        q   <= mul_q_n;
      end
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign hi   = acc[WIDTH-1:0];
  assign lo   = q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/DIV unit with HI/LO registers. Operands are reduced to
// magnitudes on issue, iterated in md_iter_core, sign-corrected in FIX.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus,
  output md_state_t      dbg_state
);

  md_state_t        state;
  logic [WIDTH-1:0] hi_q, lo_q, a_raw;
  logic             busy_q, done_q;
  logic             op_div, neg_q, neg_r, div0;

  logic             func_mul, func_div, accept, start_md;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] raw_hi, raw_lo;
  logic             core_last, core_step;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  // issue decode and operand magnitudes
  always_comb begin
    func_mul = mdfunc_is_mul(bus.MDFunc);
    func_div = mdfunc_is_div(bus.MDFunc);
    accept   = (state == MD_IDLE) && bus.Start && !bus.Cancel;
    start_md = accept && (func_mul || func_div);
    a_neg    = bus.Sign & bus.A[WIDTH-1];
    b_neg    = bus.Sign & bus.B[WIDTH-1];
    a_mag    = a_neg ? -bus.A : bus.A;
    b_mag    = b_neg ? -bus.B : bus.B;
    b_zero   = (bus.B == '0);
  end

  assign core_step = (state == MD_CALC) && !bus.Cancel;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (op_div),
    .load    (start_md),
    .step    (core_step),
    .a_in    (a_mag),
    .b_in    (b_mag),
    .hi      (raw_hi),
    .lo      (raw_lo),
    .last    (core_last)
  );

  // sign fix-up of the magnitude results
  always_comb begin
    prod_raw = {raw_hi, raw_lo};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    q_fix    = neg_q ? -raw_lo : raw_lo;
    r_fix    = neg_r ? -raw_hi : raw_hi;
  end

  // control FSM plus HI/LO, Busy and Done registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= MD_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start_md) begin
            op_div <= func_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= func_div && b_zero;
            a_raw  <= bus.A;
            busy_q <= 1'b1;
            // a zero divisor has a fixed answer, so it can skip iterating
            state  <= (func_div && b_zero && DIV0_FAST) ? MD_FIX : MD_CALC;
          end else if (accept && bus.MDFunc == MDFUNC_MTHI) begin
            hi_q <= bus.A;
          end else if (accept && bus.MDFunc == MDFUNC_MTLO) begin
            lo_q <= bus.A;
          end
        end
        MD_CALC: begin
          if (bus.Cancel) begin
            state  <= MD_IDLE;
            busy_q <= 1'b0;
          end else if (core_last) begin
            state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
          if (!bus.Cancel) begin
            done_q <= 1'b1;
            if (div0) begin
              hi_q <= a_raw;
              lo_q <= '1;
            end else if (op_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of HI/LO results plus
// latency, busy-window, cancel, move and asynchronous-reset checks.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic      clk;
  logic      rst_n;
  md_state_t dbg_state;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .DIV0_FAST(1'b1)) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] model_hi, model_lo;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: {HI, LO} for MULT/DIV from plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] f, input logic s,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0]  sa, sb, sq, sr;
    logic signed [63:0]   pa, pb;
    logic [63:0]          p;
    sa = a;
    sb = b;
    if (!f[1]) begin
      if (s) begin
        pa = sa;
        pb = sb;
        p  = pa * pb;
      end else begin
        p = {32'h0, a} * {32'h0, b};
      end
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // scoreboard: every Done pops one expected result
  always @(negedge clk) begin
    if (rst_n && bus.Done) begin
      if (exp_q.size() == 0) check_eq("unexpected_done", 64'd1, 64'd0);
      else check_eq("result", {bus.HI, bus.LO}, exp_q.pop_front());
    end
  end

  // issue one MULT/DIV; inject 1 = MTLO Start mid-op, 2 = Cancel at iteration 10
  task automatic do_op(input logic [2:0] f, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int inject);
    int k, busy_cyc, done_at, exp_lat, exp_busy;
    logic [63:0] r;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDFunc = f; bus.Sign = s; bus.A = a; bus.B = b; bus.Cancel = 1'b0;
    r = model(f, s, a, b);
    if (inject != 2) exp_q.push_back(r);
    @(negedge clk);
    check_eq("state_issue", dbg_state,
             (f[1] && b == 32'h0) ? MD_FIX : MD_CALC);
    k = 0; busy_cyc = 0; done_at = 0;
    while (k < 60 && done_at == 0) begin
      bus.Start = 1'b0; bus.Cancel = 1'b0;
      if (k == 0) begin bus.A = $urandom; bus.B = $urandom; end
      if (inject == 1 && k == 5) begin
        bus.Start = 1'b1; bus.MDFunc = MDFUNC_MTLO; bus.A = 32'hDEAD_BEEF;
      end
      if (inject == 2 && k == 10) bus.Cancel = 1'b1;
      if (bus.Busy) busy_cyc++;
      @(negedge clk);
      k++;
      if (bus.Done) done_at = k;
    end
    bus.Start = 1'b0; bus.Cancel = 1'b0;
    exp_lat  = (f[1] && b == 32'h0) ? 1 : W + 1;
    exp_busy = exp_lat;
    if (inject == 2) begin exp_lat = 0; exp_busy = 11; end
    check_eq("done_latency", done_at, exp_lat);
    check_eq("busy_cycles", busy_cyc, exp_busy);
    check_eq("busy_after", bus.Busy, 1'b0);
    if (inject == 2) begin
      check_eq("cancel_hilo", {bus.HI, bus.LO}, {model_hi, model_lo});
      check_eq("cancel_state", dbg_state, MD_IDLE);
    end else begin
      model_hi = r[63:32];
      model_lo = r[31:0];
    end
  endtask

  // MTHI/MTLO/NOP or an idle Start, optionally with Cancel asserted
  task automatic move_op(input logic [2:0] f, input logic [W-1:0] a, input logic cancel);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDFunc = f; bus.Sign = 1'b0; bus.A = a; bus.B = 32'h5; bus.Cancel = cancel;
    @(negedge clk);
    bus.Start = 1'b0; bus.Cancel = 1'b0;
    if (!cancel && f == MDFUNC_MTHI) model_hi = a;
    if (!cancel && f == MDFUNC_MTLO) model_lo = a;
    check_eq("move_busy", bus.Busy, 1'b0);
    check_eq("move_hi", bus.HI, model_hi);
    check_eq("move_lo", bus.LO, model_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] rf;
    logic       rs;
    rst_n = 1'b0;
    bus.Start = 1'b0; bus.MDFunc = MDFUNC_NOP; bus.Sign = 1'b0;
    bus.Cancel = 1'b0; bus.A = '0; bus.B = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_hi", bus.HI, 32'h0);
    check_eq("rst_lo", bus.LO, 32'h0);
    check_eq("rst_busy", bus.Busy, 1'b0);
    check_eq("rst_done", bus.Done, 1'b0);
    check_eq("rst_state", dbg_state, MD_IDLE);

    // directed vectors
    do_op(MDFUNC_MULT, 1'b1, 32'hFFFF_FFFE, 32'h3, 0);
    check_eq("mult_neg", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(MDFUNC_MULTU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_eq("multu_max", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
    do_op(MDFUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, 0);
    check_eq("div_neg", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(MDFUNC_DIVU, 1'b0, 32'h7, 32'h2, 0);
    check_eq("divu", {bus.HI, bus.LO}, 64'h0000_0001_0000_0003);
    do_op(MDFUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("div_ovf", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);
    do_op(MDFUNC_DIVU, 1'b0, 32'h1234, 32'h0, 0);
    check_eq("divu_zero", {bus.HI, bus.LO}, 64'h0000_1234_FFFF_FFFF);
    do_op(MDFUNC_DIV, 1'b1, 32'hFFFF_FF00, 32'h0, 0);

    // moves, NOP and Cancel-beats-Start in idle
    move_op(funct_to_mdfunc(FUNCT_MTHI), 32'hA5A5_0001, 1'b0);
    move_op(funct_to_mdfunc(FUNCT_MTLO), 32'h5A5A_0002, 1'b0);
    move_op(MDFUNC_NOP, 32'h1111_1111, 1'b0);
    move_op(MDFUNC_MTHI, 32'h2222_2222, 1'b1);
    move_op(MDFUNC_MULT, 32'h3333_3333, 1'b1);

    // in-flight interference
    do_op(MDFUNC_MULT, 1'b1, 32'h0001_2345, 32'hFFFF_0F0F, 1);
    do_op(MDFUNC_MULTU, 1'b0, 32'h0BAD_F00D, 32'h0000_0777, 2);

    // random mix
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      do_op(rf, rs, pick(), pick(), 0);
    end

    // asynchronous reset in the middle of CALC
    move_op(MDFUNC_MTHI, 32'hCAFE_0001, 1'b0);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDFunc = MDFUNC_MULT; bus.Sign = 1'b0; bus.A = 32'h7; bus.B = 32'h9;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_hi", bus.HI, 32'h0);
    check_eq("arst_lo", bus.LO, 32'h0);
    check_eq("arst_busy", bus.Busy, 1'b0);
    check_eq("arst_state", dbg_state, MD_IDLE);
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(MDFUNC_MULT, 1'b1, 32'h5, 32'h6, 0);
    check_eq("post_rst_lo", bus.LO, 32'd30);

    repeat (5) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
